// File: rtl/uart_rx_drain_ctrl.sv
// uart_rx_drain_ctrl: drains the UART receiver FIFO into a valid/ready byte stream
// and merges sticky status bits into one maskable interrupt.
module uart_rx_drain_ctrl #(
   parameter int TIMEOUT_CYC = 1024,
   parameter int TO_W        = 16,
   parameter int BURST_MAX   = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ctrl_en,
   input  logic       flush,
   input  logic       rx_empty,
   input  logic       rx_thr,
   input  logic       rx_busy,
   input  logic       rx_wr,
   input  logic [7:0] rx_data,
   input  logic       rx_pe,
   input  logic       rx_fre,
   input  logic       rx_ov,
   output logic       rx_read_en,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [1:0] out_err,
   input  logic [3:0] irq_mask,
   input  logic [3:0] irq_clr,
   output logic [3:0] irq_status,
   output logic       irq
);
   typedef enum logic [1:0] {IDLE, READ, WAIT, PRESENT} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [4:0]      BMAX    = 5'(BURST_MAX);

   state_t          state_q, state_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [4:0]      burst_cnt_q, burst_cnt_d;
   logic [7:0]      out_data_q, out_data_d;
   logic [1:0]      out_err_q, out_err_d;
   logic [3:0]      status_q, status_d, status_set;
   logic            rx_read_en_q, rx_read_en_d;
   logic            out_valid_q, out_valid_d;
   logic            rx_ov_q;
   logic            to_hit, trig, pop;

   always_comb begin
      to_hit      = to_cnt_q == TO_LAST;
      trig        = ctrl_en & ~rx_empty & (rx_thr | to_hit | flush);
      pop         = rx_read_en_q & ~rx_wr;
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      case (state_q)
         IDLE: begin
            state_d     = trig ? READ : IDLE;
            burst_cnt_d = trig ? 5'd0 : burst_cnt_q;
         end
         // a same-cycle FIFO write swallows the pop, so it is re-issued
         READ: state_d = rx_wr ? READ : WAIT;
         WAIT: begin
            state_d     = PRESENT;
            out_data_d  = rx_data;
            out_err_d   = {rx_pe, rx_fre};
            burst_cnt_d = burst_cnt_q + 5'd1;
         end
         default: if (out_ready)
            state_d = (ctrl_en & ~rx_empty & (burst_cnt_q < BMAX)) ? READ : IDLE;
      endcase
      // held at the terminal value so a blocked timeout fires once re-enabled
      to_cnt_d     = (rx_busy | rx_empty | pop) ? '0 :
                     (state_q == IDLE && !to_hit) ? to_cnt_q + 1'b1 : to_cnt_q;
      status_set   = {rx_ov & ~rx_ov_q,
                      (state_q == WAIT) & (rx_pe | rx_fre),
                      (state_q == IDLE) & trig & ~rx_thr & to_hit,
                      (state_q == IDLE) & trig & rx_thr};
      status_d     = (status_q & ~irq_clr) | status_set;
      rx_read_en_d = state_d == READ;
      out_valid_d  = state_d == PRESENT;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         to_cnt_q     <= '0;
         burst_cnt_q  <= '0;
         out_data_q   <= '0;
         out_err_q    <= '0;
         status_q     <= '0;
         rx_read_en_q <= 1'b0;
         out_valid_q  <= 1'b0;
         rx_ov_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         to_cnt_q     <= to_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
         out_data_q   <= out_data_d;
         out_err_q    <= out_err_d;
         status_q     <= status_d;
         rx_read_en_q <= rx_read_en_d;
         out_valid_q  <= out_valid_d;
         rx_ov_q      <= rx_ov;
      end
   end

   assign rx_read_en = rx_read_en_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_err    = out_err_q;
   assign irq_status = status_q;
   assign irq        = |(status_q & irq_mask);
endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// tb_uart_rx_drain_ctrl: directed bench for uart_rx_drain_ctrl with a small
// receiver FIFO model feeding rx_data/rx_empty.
module tb_uart_rx_drain_ctrl;
   logic       clk = 1'b0;
   logic       resetn, ctrl_en, flush, rx_empty, rx_thr, rx_busy, rx_wr;
   logic [7:0] rx_data;
   logic       rx_pe, rx_fre, rx_ov, rx_read_en, out_valid, out_ready;
   logic [7:0] out_data;
   logic [1:0] out_err;
   logic [3:0] irq_mask, irq_clr, irq_status;
   logic       irq;

   uart_rx_drain_ctrl #(.TIMEOUT_CYC(8), .TO_W(16), .BURST_MAX(16)) dut (
      .clk(clk), .resetn(resetn), .ctrl_en(ctrl_en), .flush(flush),
      .rx_empty(rx_empty), .rx_thr(rx_thr), .rx_busy(rx_busy), .rx_wr(rx_wr),
      .rx_data(rx_data), .rx_pe(rx_pe), .rx_fre(rx_fre), .rx_ov(rx_ov),
      .rx_read_en(rx_read_en), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err), .irq_mask(irq_mask),
      .irq_clr(irq_clr), .irq_status(irq_status), .irq(irq)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:63];
   logic       mpe [0:63];
   logic [7:0] got [0:63];
   int wp = 0, rp = 0, nre = 0, npop = 0, ng = 0;
   int checks = 0, failures = 0;
   int b_re, b_pop, b_g;
   logic stable, quiet;

   always_comb rx_empty = (wp == rp);

   // receiver model: a pop lost to a concurrent write leaves the FIFO untouched
   always @(posedge clk) begin
      if (rx_read_en) nre <= nre + 1;
      if (rx_read_en && !rx_wr && wp != rp) begin
         rx_data <= mem[rp];
         rx_pe   <= mpe[rp];
         rp      <= rp + 1;
         npop    <= npop + 1;
      end
      if (out_valid && out_ready) begin
         got[ng] <= out_data;
         ng      <= ng + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic pe);
      mem[wp] = d;
      mpe[wp] = pe;
      wp++;
   endtask

   task automatic mark();
      b_re = nre; b_pop = npop; b_g = ng;
   endtask

   task automatic wait_valid(input int n);
      int k = 0;
      while (!out_valid && k < n) begin
         @(negedge clk);
         k++;
      end
      check("wait_valid", out_valid, 1);
   endtask

   task automatic clear_all();
      @(negedge clk) irq_clr = 4'hF;
      @(negedge clk) irq_clr = 4'h0;
   endtask

   initial begin
      resetn = 0; ctrl_en = 0; flush = 0; rx_thr = 0; rx_busy = 0; rx_wr = 0;
      rx_data = 0; rx_pe = 0; rx_fre = 0; rx_ov = 0; out_ready = 0;
      irq_mask = 0; irq_clr = 0;
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_rd", rx_read_en, 0);
      check("rst_status", irq_status, 0);
      check("rst_data", out_data, 0);
      resetn = 1;

      // threshold burst of four, with trigger-to-valid latency
      @(negedge clk);
      mark();
      rx_thr = 1; ctrl_en = 1; out_ready = 1;
      push(8'hA1, 0); push(8'hA2, 0); push(8'hA3, 0); push(8'hA4, 0);
      @(negedge clk) check("lat_rd", rx_read_en, 1);
      @(negedge clk) check("lat_wait", rx_read_en, 0);
      @(negedge clk);
      check("lat_valid", out_valid, 1);
      check("lat_data", out_data, 8'hA1);
      repeat (12) @(negedge clk);
      check("thr_pops", npop - b_pop, 4);
      check("thr_rd", nre - b_re, 4);
      check("thr_b1", got[b_g], 8'hA1);
      check("thr_b2", got[b_g+1], 8'hA2);
      check("thr_b3", got[b_g+2], 8'hA3);
      check("thr_b4", got[b_g+3], 8'hA4);
      check("thr_status", irq_status, 4'b0001);
      check("thr_idle", out_valid, 0);
      clear_all();
      check("thr_clr", irq_status, 0);

      // consumer stall holds the byte and blocks further pops
      mark();
      out_ready = 0;
      push(8'h11, 0); push(8'h22, 0);
      wait_valid(10);
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!out_valid || out_data !== 8'h11) stable = 0;
      end
      check("stall_stable", stable, 1);
      check("stall_rd", nre - b_re, 1);
      out_ready = 1;
      repeat (8) @(negedge clk);
      check("stall_cnt", ng - b_g, 2);
      check("stall_b1", got[b_g], 8'h11);
      check("stall_b2", got[b_g+1], 8'h22);
      rx_thr = 0;
      clear_all();

      // idle timeout, restarted by an rx_busy pulse
      mark();
      push(8'h5A, 0);
      quiet = 1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (rx_read_en) quiet = 0;
         if (i == 4) rx_busy = 1;
         if (i == 5) rx_busy = 0;
      end
      check("to_quiet", quiet, 1);
      @(negedge clk) check("to_rd", rx_read_en, 1);
      repeat (4) @(negedge clk);
      check("to_byte", got[b_g], 8'h5A);
      check("to_status", irq_status, 4'b0010);
      irq_mask = 4'b0010;
      #1 check("to_irq", irq, 1);
      irq_mask = 0;
      clear_all();

      // write collision during READ re-issues the pop
      rx_thr = 1;
      mark();
      push(8'h33, 0);
      @(negedge clk);
      check("coll_rd1", rx_read_en, 1);
      rx_wr = 1;
      @(negedge clk);
      check("coll_rd2", rx_read_en, 1);
      rx_wr = 0;
      @(negedge clk) check("coll_wait", rx_read_en, 0);
      @(negedge clk) check("coll_data", out_data, 8'h33);
      repeat (3) @(negedge clk);
      check("coll_pops", npop - b_pop, 1);
      check("coll_rdcnt", nre - b_re, 2);
      check("coll_once", ng - b_g, 1);
      clear_all();

      // error status: set wins over same-cycle clear
      push(8'hC4, 1);
      @(negedge clk);
      @(negedge clk) irq_clr = 4'b0100;
      @(negedge clk);
      irq_clr = 0;
      check("err_sticky", irq_status[2], 1);
      check("err_bits", out_err, 2'b10);
      repeat (3) @(negedge clk);
      @(negedge clk) irq_clr = 4'b0100;
      @(negedge clk) irq_clr = 0;
      check("err_clr", irq_status, 4'b0001);
      clear_all();

      // overrun rising edge and its mask
      rx_ov = 1;
      @(negedge clk);
      @(negedge clk);
      check("ov_status", irq_status, 4'b1000);
      check("ov_masked", irq, 0);
      irq_mask = 4'b1000;
      #1 check("ov_irq", irq, 1);
      rx_ov = 0; irq_mask = 0;
      clear_all();

      // disabled holds off; flush starts a burst without a status bit
      rx_thr = 0; ctrl_en = 0;
      mark();
      push(8'h66, 0);
      repeat (3) @(negedge clk);
      check("dis_hold", nre - b_re, 0);
      ctrl_en = 1; flush = 1;
      @(negedge clk);
      flush = 0;
      check("flush_rd", rx_read_en, 1);
      repeat (4) @(negedge clk);
      check("flush_byte", got[b_g], 8'h66);
      check("flush_status", irq_status, 0);

      // reset while presenting drops the byte
      rx_thr = 1; out_ready = 0;
      push(8'h77, 0);
      wait_valid(10);
      @(negedge clk) resetn = 0;
      #1;
      check("rstp_valid", out_valid, 0);
      check("rstp_data", out_data, 0);
      @(negedge clk) resetn = 1;
      mark();
      repeat (5) @(negedge clk);
      check("rstp_nopop", nre - b_re, 0);
      check("rstp_status", irq_status, 0);
      check("rstp_idle", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
